// File: rtl/cva6_ypb_nchan_mux.sv
// Merges NumChan YPB requester channels onto one downstream memory port.
// Responses are routed back in order through a FIFO of channel tags.
module cva6_ypb_nchan_mux #(
    parameter int unsigned NumChan        = 6,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          RoundRobin     = 1'b1,
    localparam int unsigned IdxW = (NumChan > 1) ? $clog2(NumChan) : 1,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1),
    localparam int unsigned BeW  = DataWidth / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumChan-1:0]           req_valid_i,
    output logic [NumChan-1:0]           req_ready_o,
    input  logic [NumChan*AddrWidth-1:0] req_addr_i,
    input  logic [NumChan-1:0]           req_we_i,
    input  logic [NumChan*BeW-1:0]       req_be_i,
    input  logic [NumChan*DataWidth-1:0] req_wdata_i,
    output logic [NumChan-1:0]           rsp_valid_o,
    output logic [DataWidth-1:0]         rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic                         mst_req_valid_o,
    input  logic                         mst_req_ready_i,
    output logic [AddrWidth-1:0]         mst_req_addr_o,
    output logic                         mst_req_we_o,
    output logic [BeW-1:0]               mst_req_be_o,
    output logic [DataWidth-1:0]         mst_req_wdata_o,
    input  logic                         mst_rsp_valid_i,
    input  logic [DataWidth-1:0]         mst_rsp_rdata_i,
    input  logic                         mst_rsp_err_i,
    output logic [CntW-1:0]              outstanding_o,
    output logic                         rsp_orphan_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] grant;
    logic            grant_valid;

    logic [IdxW-1:0] tag_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [IdxW-1:0] head_tag;
    logic            full, empty, hs, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Fullness comes from registered count only, so a response never unblocks a request combinationally.
    assign full     = (count_q == CntW'(MaxOutstanding));
    assign empty    = (count_q == '0);
    assign head_tag = tag_mem[rd_ptr_q];

    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        grant       = lock_idx_q;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        if (state_q == ARB_LOCKED) begin
            grant_valid = req_valid_i[lock_idx_q] && !full;
        end else begin
            for (int unsigned k = 0; k < NumChan; k++) begin
                cand = RoundRobin ? (k + 32'(rr_ptr_q)) : k;
                if (cand >= NumChan) begin
                    cand = cand - NumChan;
                end
                cand_idx = cand[IdxW-1:0];
                if (!grant_valid && !full && req_valid_i[cand_idx]) begin
                    grant       = cand_idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign mst_req_valid_o = rst_ni && grant_valid;
    assign hs              = mst_req_valid_o && mst_req_ready_i;
    assign push            = hs;
    assign pop             = rst_ni && mst_rsp_valid_i && !empty;

    assign mst_req_addr_o  = req_addr_i[grant*AddrWidth +: AddrWidth];
    assign mst_req_we_o    = req_we_i[grant];
    assign mst_req_be_o    = req_be_i[grant*BeW +: BeW];
    assign mst_req_wdata_o = req_wdata_i[grant*DataWidth +: DataWidth];

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (hs) begin
            req_ready_o[grant] = 1'b1;
        end
        if (pop) begin
            rsp_valid_o[head_tag] = 1'b1;
        end
    end

    assign rsp_rdata_o   = mst_rsp_rdata_i;
    assign rsp_err_o     = pop && mst_rsp_err_i;
    assign rsp_orphan_o  = rst_ni && mst_rsp_valid_i && empty;
    assign outstanding_o = count_q;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (hs) begin
            state_d = ARB_FREE;
            if (RoundRobin) begin
                rr_ptr_d = (grant == IdxW'(NumChan - 1)) ? '0 : grant + 1'b1;
            end
        end else if (mst_req_valid_o) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = grant;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_FREE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                tag_mem[wr_ptr_q] <= grant;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
